// File: rtl/residue_pkg.sv
// Shared types and the end-around-carry modulo-(2^n-1) add for the residue datapath.
// Combinational helper only; width is supplied by the caller, up to RES_MAX_W bits.
package residue_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ACC  = 2'b10,
        OP_LOAD = 2'b11
    } residue_op_t;

    localparam int RES_MAX_W = 32;

    // x + y mod (2^n-1), result canonical in [0, 2^n-2]; bits above n are ignored.
    function automatic logic [RES_MAX_W-1:0] residue_mod_add(
        input logic [RES_MAX_W-1:0] x,
        input logic [RES_MAX_W-1:0] y,
        input int unsigned          n
    );
        logic [RES_MAX_W:0] mask;
        logic [RES_MAX_W:0] raw;
        logic [RES_MAX_W:0] t;
        mask = ((RES_MAX_W+1)'(1) << n) - (RES_MAX_W+1)'(1);
        raw  = ({1'b0, x} & mask) + ({1'b0, y} & mask);
        t    = (raw & mask) + ((raw >> n) & (RES_MAX_W+1)'(1));
        if (t == mask) t = '0;
        return RES_MAX_W'(t);
    endfunction

endpackage

// File: rtl/residue_mod_alu_if.sv
// Operand/result handshake bundle for the residue ALU.
// Valid/ready on both sides; acc_r is a free-running status view.
interface residue_mod_alu_if
    import residue_pkg::*;
#(
    parameter int N = 3
);
    logic        in_valid;
    logic        in_ready;
    residue_op_t in_op;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [N-1:0] out_r;
    residue_op_t out_op;
    logic [N-1:0] acc_r;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_r, out_op, acc_r
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_r, out_op, acc_r
    );
endinterface

// File: rtl/residue_mod_adder.sv
// Combinational modulo-(2^N-1) adder producing a canonical residue.
// Zero latency; no flow control.
module residue_mod_adder
    import residue_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] r
);
    assign r = N'(residue_mod_add(RES_MAX_W'(x), RES_MAX_W'(y), N));
endmodule

// File: rtl/residue_mod_alu.sv
// Two-stage modulo-(2^N-1) ALU (add/sub/acc/load); result valid one edge after the S1 capture edge.
// Backpressure: stalled output holds; S1 holds and in_ready drops when both stages are full.
module residue_mod_alu
    import residue_pkg::*;
#(
    parameter int N = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    residue_mod_alu_if.slave  bus
);
    logic         s1_valid_q, s1_valid_d;
    residue_op_t  s1_op_q, s1_op_d;
    logic [N-1:0] s1_a_q, s1_a_d;
    logic [N-1:0] s1_b_q, s1_b_d;
    logic         out_valid_q, out_valid_d;
    logic [N-1:0] out_r_q, out_r_d;
    residue_op_t  out_op_q, out_op_d;
    logic [N-1:0] acc_q, acc_d;

    logic         advance;
    logic         in_rdy;
    logic         accept;
    logic [N-1:0] add_x, add_y, add_r;

    residue_mod_adder #(.N(N)) u_adder (
        .x (add_x),
        .y (add_y),
        .r (add_r)
    );

    always_comb begin
        advance = s1_valid_q & (~out_valid_q | bus.out_ready);
        in_rdy  = ~s1_valid_q | advance;
        accept  = bus.in_valid & in_rdy;

        // SUB negates b by one's complement; LOAD canonicalises a by adding zero.
        add_x = s1_a_q;
        add_y = s1_b_q;
        case (s1_op_q)
            OP_ADD:  begin add_x = s1_a_q; add_y = s1_b_q;  end
            OP_SUB:  begin add_x = s1_a_q; add_y = ~s1_b_q; end
            OP_ACC:  begin add_x = acc_q;  add_y = s1_a_q;  end
            OP_LOAD: begin add_x = s1_a_q; add_y = '0;      end
            default: begin add_x = s1_a_q; add_y = s1_b_q;  end
        endcase

        s1_valid_d = accept ? 1'b1 : (advance ? 1'b0 : s1_valid_q);
        s1_op_d    = accept ? bus.in_op : s1_op_q;
        s1_a_d     = accept ? bus.in_a  : s1_a_q;
        s1_b_d     = accept ? bus.in_b  : s1_b_q;

        out_valid_d = advance ? 1'b1 : (bus.out_ready ? 1'b0 : out_valid_q);
        out_r_d     = advance ? add_r   : out_r_q;
        out_op_d    = advance ? s1_op_q : out_op_q;

        acc_d = acc_q;
        if (advance && (s1_op_q == OP_ACC || s1_op_q == OP_LOAD)) acc_d = add_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_ADD;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_op_q    <= OP_ADD;
            acc_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            out_valid_q <= out_valid_d;
            out_r_q     <= out_r_d;
            out_op_q    <= out_op_d;
            acc_q       <= acc_d;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_valid_q;
    assign bus.out_r     = out_r_q;
    assign bus.out_op    = out_op_q;
    assign bus.acc_r     = acc_q;
endmodule

// File: tb/tb_residue_mod_alu.sv
// Bench for residue_mod_alu at N=3 and N=5 against an in-order modular-arithmetic model.
module tb_residue_mod_alu;
    import residue_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    residue_mod_alu_if #(.N(3)) if3 ();
    residue_mod_alu_if #(.N(5)) if5 ();

    residue_mod_alu #(.N(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));
    residue_mod_alu #(.N(5)) u5 (.clk(clk), .rst_n(rst_n), .bus(if5));

    typedef struct {
        int r;
        int op;
        int acc;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   cur   = 0;
    int   M     = 7;
    int   macc  = 0;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int canon(input int x);
        return x % M;
    endfunction

    task automatic drive(input bit v, input int op, input int a, input int b, input bit ordy);
        if (cur == 0) begin
            if3.in_valid = v; if3.in_op = residue_op_t'(op[1:0]);
            if3.in_a = a[2:0]; if3.in_b = b[2:0]; if3.out_ready = ordy;
            if5.in_valid = 1'b0; if5.in_op = OP_ADD; if5.in_a = '0; if5.in_b = '0; if5.out_ready = 1'b1;
        end else begin
            if5.in_valid = v; if5.in_op = residue_op_t'(op[1:0]);
            if5.in_a = a[4:0]; if5.in_b = b[4:0]; if5.out_ready = ordy;
            if3.in_valid = 1'b0; if3.in_op = OP_ADD; if3.in_a = '0; if3.in_b = '0; if3.out_ready = 1'b1;
        end
    endtask

    task automatic sample(output int ov, output int r, output int op, output int ac, output int ir);
        if (cur == 0) begin
            ov = int'(if3.out_valid); r = int'(if3.out_r); op = int'(if3.out_op);
            ac = int'(if3.acc_r); ir = int'(if3.in_ready);
        end else begin
            ov = int'(if5.out_valid); r = int'(if5.out_r); op = int'(if5.out_op);
            ac = int'(if5.acc_r); ir = int'(if5.in_ready);
        end
    endtask

    // One clock cycle: drive, check readiness, advance the model, check outputs.
    task automatic step(input bit v, input int op, input int a, input int b, input bit ordy,
                        output bit took);
        int ov, r, o, ac, ir, ca, cb;
        bit pop;
        exp_t e;
        drive(v, op, a, b, ordy);
        #1;
        sample(ov, r, o, ac, ir);
        check("in_ready", ir, (q.size() == 2 && !ordy) ? 0 : 1);
        took = v && (ir == 1);
        pop  = (ov == 1) && ordy;
        e = '{r: 0, op: op, acc: 0, cyc: 0};
        if (took) begin
            ca = canon(a);
            cb = canon(b);
            case (op)
                0: e.r = (ca + cb) % M;
                1: e.r = (ca - cb + M) % M;
                2: begin macc = (macc + ca) % M; e.r = macc; end
                default: begin macc = ca; e.r = macc; end
            endcase
            e.acc = macc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pop && q.size() > 0) void'(q.pop_front());
        if (took) begin
            e.cyc = cyc;
            q.push_back(e);
        end
        sample(ov, r, o, ac, ir);
        check("out_valid", ov, (q.size() > 0 && q[0].cyc < cyc) ? 1 : 0);
        if (ov == 1 && q.size() > 0 && q[0].cyc < cyc) begin
            check("out_r", r, q[0].r);
            check("out_op", o, q[0].op);
            check("acc_r", ac, q[0].acc);
        end
    endtask

    task automatic idle(input int n);
        bit t;
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 1'b1, t);
    endtask

    // Random stream that keeps a transaction stable until it is accepted.
    task automatic rand_run(input int n, input int rdy_pct);
        bit t = 1'b1;
        int op = 0, a = 0, b = 0;
        bit v = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (t || !v) begin
                v  = ($urandom_range(0, 3) != 0);
                op = $urandom_range(0, 3);
                a  = $urandom_range(0, M);
                b  = $urandom_range(0, M);
            end
            step(v, op, a, b, ($urandom_range(1, 100) <= rdy_pct), t);
        end
    endtask

    initial begin
        bit t;
        int ov, r, o, ac, ir;
        int a, b, op;

        rst_n = 1'b0;
        cur = 0;
        drive(1'b0, 0, 0, 0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid3", int'(if3.out_valid), 0);
        check("rst_out_r3", int'(if3.out_r), 0);
        check("rst_out_op3", int'(if3.out_op), 0);
        check("rst_acc3", int'(if3.acc_r), 0);
        check("rst_out_valid5", int'(if5.out_valid), 0);
        check("rst_acc5", int'(if5.acc_r), 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready3", int'(if3.in_ready), 1);
        check("rst_in_ready5", int'(if5.in_ready), 1);
        @(posedge clk);
        #1;

        // N=3 ADD, back to back
        step(1'b1, 0, 3, 5, 1'b1, t);
        step(1'b1, 0, 7, 7, 1'b1, t);
        step(1'b1, 0, 6, 1, 1'b1, t);
        step(1'b1, 0, 4, 2, 1'b1, t);
        // N=3 SUB
        step(1'b1, 1, 2, 5, 1'b1, t);
        step(1'b1, 1, 5, 0, 1'b1, t);
        step(1'b1, 1, 5, 7, 1'b1, t);
        step(1'b1, 1, 0, 0, 1'b1, t);
        idle(2);

        // Accumulate with interleaved ADDs
        step(1'b1, 3, 7, 0, 1'b1, t);
        step(1'b1, 2, 6, 0, 1'b1, t);
        step(1'b1, 0, 1, 2, 1'b1, t);
        step(1'b1, 2, 6, 0, 1'b1, t);
        step(1'b1, 2, 6, 0, 1'b1, t);
        step(1'b1, 0, 3, 3, 1'b1, t);
        step(1'b1, 2, 6, 0, 1'b1, t);
        idle(2);
        check("acc_final", int'(if3.acc_r), 3);

        // Backpressure: out_ready low for 5 cycles under a continuous stream
        t = 1'b1;
        op = 0; a = 0; b = 0;
        for (int i = 0; i < 11; i++) begin
            if (t) begin
                op = $urandom_range(0, 3);
                a  = $urandom_range(0, 7);
                b  = $urandom_range(0, 7);
            end
            step(1'b1, op, a, b, (i >= 5), t);
        end
        idle(3);

        // Reset with ops in flight
        step(1'b1, 2, 5, 0, 1'b0, t);
        step(1'b1, 0, 1, 1, 1'b0, t);
        step(1'b1, 3, 4, 0, 1'b0, t);
        #2;
        rst_n = 1'b0;
        #1;
        sample(ov, r, o, ac, ir);
        check("midrst_out_valid", ov, 0);
        check("midrst_acc", ac, 0);
        check("midrst_out_r", r, 0);
        q.delete();
        macc = 0;
        drive(1'b0, 0, 0, 0, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready", int'(if3.in_ready), 1);
        @(posedge clk);
        #1;
        idle(3);
        rand_run(60, 70);
        idle(4);

        // N=5 phase
        cur = 1;
        M = 31;
        macc = 0;
        step(1'b1, 0, 31, 31, 1'b1, t);
        step(1'b1, 0, 16, 16, 1'b1, t);
        step(1'b1, 1, 3, 31, 1'b1, t);
        step(1'b1, 3, 31, 0, 1'b1, t);
        step(1'b1, 2, 30, 0, 1'b1, t);
        step(1'b1, 2, 30, 0, 1'b1, t);
        idle(2);
        rand_run(200, 75);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
